// File: rtl/key_cmd_queue.sv
// Key press command queue: collects per-key press pulses, grants one per cycle
// by fixed priority (DOWN > ROT > LEFT > RIGHT) into a small FIFO of 2-bit commands.
module key_cmd_queue #(
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     k_left,
   input  logic                     k_right,
   input  logic                     k_rot,
   input  logic                     k_down,
   output logic                     cmd_valid,
   output logic [1:0]               cmd,
   input  logic                     cmd_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic [DROP_W-1:0]        drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [3:0]        pend_q, pend_d;
   logic [1:0]        mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic [3:0] flags;
   logic [3:0] grant_vec;
   logic [1:0] grant_code;
   logic       push;
   logic       pop;
   logic       coalesce;

   assign flags = {k_down, k_rot, k_right, k_left};

   // Full is judged on the start-of-cycle level, so a same-cycle pop never frees a slot early.
   always_comb begin
      grant_vec  = '0;
      grant_code = '0;
      push       = 1'b0;
      if (level_q != FULL_LVL) begin
         if (pend_q[3]) begin
            grant_vec  = 4'b1000;
            grant_code = 2'd3;
            push       = 1'b1;
         end else if (pend_q[2]) begin
            grant_vec  = 4'b0100;
            grant_code = 2'd2;
            push       = 1'b1;
         end else if (pend_q[0]) begin
            grant_vec  = 4'b0001;
            grant_code = 2'd0;
            push       = 1'b1;
         end else if (pend_q[1]) begin
            grant_vec  = 4'b0010;
            grant_code = 2'd1;
            push       = 1'b1;
         end
      end
   end

   assign pop      = (level_q != '0) && cmd_ready;
   assign coalesce = |(flags & pend_q & ~grant_vec);

   always_comb begin
      pend_d   = (pend_q & ~grant_vec) | flags;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      drop_d = drop_q;
      if (coalesce && !(&drop_q)) begin
         drop_d = drop_q + DROP_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         drop_q   <= '0;
      end else begin
         pend_q   <= pend_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         drop_q   <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= grant_code;
      end
   end

   assign cmd_valid = (level_q != '0);
   assign cmd       = mem_q[rd_ptr_q];
   assign level     = level_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_key_cmd_queue.sv
// Randomized phases against a queue-based reference model; a monitor checks
// every popped command against the expected-command scoreboard.
module tb_key_cmd_queue;

   localparam int DEPTH  = 4;
   localparam int DROP_W = 8;
   localparam int DMAX   = (1 << DROP_W) - 1;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   k_left, k_right, k_rot, k_down;
   logic                   cmd_valid;
   logic [1:0]             cmd;
   logic                   cmd_ready;
   logic [$clog2(DEPTH):0] level;
   logic [DROP_W-1:0]      drop_cnt;

   key_cmd_queue #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .k_left    (k_left),
      .k_right   (k_right),
      .k_rot     (k_rot),
      .k_down    (k_down),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .cmd_ready (cmd_ready),
      .level     (level),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   bit  m_pend [4];
   int  m_q [$];
   int  m_drop;
   int  exp_q [$];
   bit  m_was_reset;

   function automatic void check(input string name, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endfunction

   // One clock of the specified behaviour, applied to the model.
   function automatic void model_step(input bit r, input bit f [4], input bit rdy);
      int prio [4] = '{3, 2, 0, 1};
      int g;
      bit coal;
      if (r) begin
         for (int k = 0; k < 4; k++) m_pend[k] = 1'b0;
         m_q.delete();
         exp_q.delete();
         m_drop = 0;
         m_was_reset = 1'b1;
         return;
      end
      m_was_reset = 1'b0;
      g = -1;
      if (m_q.size() < DEPTH) begin
         for (int i = 0; i < 4; i++) begin
            if (g < 0 && m_pend[prio[i]]) g = prio[i];
         end
      end
      if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
      if (g >= 0) begin
         m_q.push_back(g);
         exp_q.push_back(g);
      end
      coal = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (f[k] && m_pend[k] && k != g) coal = 1'b1;
         m_pend[k] = (m_pend[k] && k != g) || f[k];
      end
      if (coal && m_drop < DMAX) m_drop++;
   endfunction

   task automatic step(input bit r, input bit f [4], input bit rdy);
      rst       = r;
      k_left    = f[0];
      k_right   = f[1];
      k_rot     = f[2];
      k_down    = f[3];
      cmd_ready = r ? 1'b0 : rdy;
      model_step(r, f, r ? 1'b0 : rdy);
      @(posedge clk);
      #1;
      check("level", int'(level), m_q.size());
      check("cmd_valid", int'(cmd_valid), int'(m_q.size() > 0));
      check("drop_cnt", int'(drop_cnt), m_drop);
      if (m_q.size() > 0) check("cmd_head", int'(cmd), m_q[0]);
      if (m_was_reset) check("cmd_after_reset", int'(cmd), 0);
   endtask

   task automatic rand_step(input bit r, input int pf, input int pmask, input int pr);
      bit f [4];
      for (int k = 0; k < 4; k++)
         f[k] = pmask[k] && ($urandom_range(99) < pf);
      step(r, f, $urandom_range(99) < pr);
   endtask

   // Scoreboard monitor: a pop happens on the coming edge when valid & ready.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL pop_unexpected: got cmd %0d expected no entry", cmd);
            end else begin
               check("pop_cmd", int'(cmd), exp_q.pop_front());
            end
         end
      end
   end

   // phase table: flag %, key mask, ready %, cycles
   int ph_pf   [9] = '{10,  50,   100,  60,  30,  20,  70,  100, 5};
   int ph_mask [9] = '{15,  15,   1,    1,   15,  12,  15,  1,   15};
   int ph_pr   [9] = '{50,  0,    0,    0,   100, 70,  30,  0,   90};
   int ph_len  [9] = '{60,  20,   20,   300, 60,  80,  80,  30,  60};

   initial begin
      bit f [4];
      bit z [4] = '{0, 0, 0, 0};
      bit all [4] = '{1, 1, 1, 1};
      bit dn [4] = '{0, 0, 0, 1};
      bit rt [4] = '{0, 0, 1, 0};

      m_drop = 0;
      step(1'b1, all, 1'b0);
      step(1'b1, z, 1'b0);

      // single rotate, then pop
      step(1'b0, rt, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, z, 1'b0);
      step(1'b0, z, 1'b1);
      step(1'b0, z, 1'b0);

      // four simultaneous keys
      step(1'b0, all, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, z, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, z, 1'b1);

      // down pressed again exactly in its grant cycle
      step(1'b0, dn, 1'b0);
      step(1'b0, dn, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, z, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, z, 1'b1);

      for (int p = 0; p < 9; p++) begin
         for (int c = 0; c < ph_len[p]; c++) rand_step(1'b0, ph_pf[p], ph_mask[p], ph_pr[p]);
         if (p == 6) begin
            // reset with a partly full queue and pending keys
            step(1'b1, all, 1'b0);
            step(1'b0, rt, 1'b0);
            for (int i = 0; i < 3; i++) step(1'b0, z, 1'b0);
         end
      end

      for (int c = 0; c < 400; c++) rand_step($urandom_range(99) < 2, 35, 15, 60);

      for (int i = 0; i < 20; i++) step(1'b0, z, 1'b1);
      check("scoreboard_drained", exp_q.size(), 0);
      check("model_drained", m_q.size(), 0);
      for (int k = 0; k < 4; k++) f[k] = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
